// File: rtl/ls_image_feeder.sv
// Image buffer for the light separator: loads N images over valid/ready,
// then replays them gap-free, one pixel per clock, on a start pulse.
module ls_image_feeder #(
   parameter int PixelPrecision = 8,
   parameter int Row            = 8,
   parameter int Col            = 8,
   parameter int N              = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_clr,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [PixelPrecision-1:0] ld_data,
   input  logic                      start,
   output logic                      busy,
   output logic                      loaded,
   output logic [PixelPrecision-1:0] ImInput,
   output logic                      px_valid,
   output logic                      px_first,
   output logic                      px_last,
   output logic [3:0]                img_idx
);

   localparam int DEPTH = N * Row * Col;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RW    = (Row > 1) ? $clog2(Row) : 1;
   localparam int CW    = (Col > 1) ? $clog2(Col) : 1;

   typedef enum logic [1:0] {
      S_LOAD,
      S_READY,
      S_STREAM
   } state_t;

   state_t                    state_q;
   logic [AW-1:0]             wptr_q;
   logic [AW-1:0]             raddr_q;
   logic [CW-1:0]             c_q;
   logic [RW-1:0]             r_q;
   logic [3:0]                i_q;
   logic                      done_q;
   logic [PixelPrecision-1:0] rd_q;
   logic                      s1_v_q;
   logic                      s1_first_q;
   logic                      s1_last_q;
   logic [3:0]                s1_img_q;
   logic [PixelPrecision-1:0] pix_q;
   logic                      pv_q;
   logic                      pf_q;
   logic                      pl_q;
   logic [3:0]                img_q;

   logic [PixelPrecision-1:0] mem [DEPTH];

   logic we;
   logic iss;
   logic c_end;
   logic r_end;
   logic a_end;

   assign we    = (state_q == S_LOAD) && ld_valid && !rst && !ld_clr;
   assign iss   = (state_q == S_STREAM) && !done_q;
   assign c_end = (c_q == CW'(Col - 1));
   assign r_end = (r_q == RW'(Row - 1));
   assign a_end = c_end && r_end && (i_q == 4'(N - 1));

   assign ld_ready = (state_q == S_LOAD);
   assign loaded   = (state_q == S_READY);
   assign busy     = (state_q == S_STREAM);
   assign ImInput  = pix_q;
   assign px_valid = pv_q;
   assign px_first = pf_q;
   assign px_last  = pl_q;
   assign img_idx  = img_q;

   // Buffer has no reset; the read port is registered every cycle.
   always_ff @(posedge clk) begin
      if (we) mem[wptr_q] <= ld_data;
      rd_q <= mem[raddr_q];
   end

   always_ff @(posedge clk) begin
      if (rst || ld_clr) begin
         state_q    <= S_LOAD;
         wptr_q     <= '0;
         raddr_q    <= '0;
         c_q        <= '0;
         r_q        <= '0;
         i_q        <= '0;
         done_q     <= 1'b0;
         s1_v_q     <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_img_q   <= '0;
         pix_q      <= '0;
         pv_q       <= 1'b0;
         pf_q       <= 1'b0;
         pl_q       <= 1'b0;
         img_q      <= '0;
      end else begin
         unique case (state_q)
            S_LOAD: begin
               if (ld_valid) begin
                  if (wptr_q == AW'(DEPTH - 1)) begin
                     wptr_q  <= '0;
                     state_q <= S_READY;
                  end else begin
                     wptr_q <= wptr_q + AW'(1);
                  end
               end
            end
            S_READY: begin
               if (start) state_q <= S_STREAM;
            end
            S_STREAM: begin
               if (pl_q) begin
                  state_q <= S_READY;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= S_LOAD;
         endcase

         // Address walk: column, then row, then image.
         if (iss) begin
            if (a_end) begin
               raddr_q <= '0;
               c_q     <= '0;
               r_q     <= '0;
               i_q     <= '0;
               done_q  <= 1'b1;
            end else begin
               raddr_q <= raddr_q + AW'(1);
               c_q     <= c_end ? '0 : c_q + CW'(1);
               if (c_end) begin
                  r_q <= r_end ? '0 : r_q + RW'(1);
                  if (r_end) i_q <= i_q + 4'd1;
               end
            end
         end

         s1_v_q     <= iss;
         s1_first_q <= iss && (raddr_q == '0);
         s1_last_q  <= iss && a_end;
         s1_img_q   <= i_q;

         pv_q  <= s1_v_q;
         pix_q <= s1_v_q ? rd_q : '0;
         pf_q  <= s1_first_q;
         pl_q  <= s1_last_q;
         img_q <= s1_img_q;
      end
   end

endmodule

// File: tb/tb_ls_image_feeder.sv
// Randomized bench for ls_image_feeder against an array model of the
// buffered image set and its expected raster replay.
module tb_ls_image_feeder;

   localparam int D   = 256;
   localparam int PIX = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld_clr;
   logic       ld_valid;
   logic       ld_ready;
   logic [7:0] ld_data;
   logic       start;
   logic       busy;
   logic       loaded;
   logic [7:0] ImInput;
   logic       px_valid;
   logic       px_first;
   logic       px_last;
   logic [3:0] img_idx;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] model [D];

   ls_image_feeder #(
      .PixelPrecision(8),
      .Row           (8),
      .Col           (8),
      .N             (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ld_clr  (ld_clr),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_data (ld_data),
      .start   (start),
      .busy    (busy),
      .loaded  (loaded),
      .ImInput (ImInput),
      .px_valid(px_valid),
      .px_first(px_first),
      .px_last (px_last),
      .img_idx (img_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_pxv"}, px_valid, 0);
      check({tag, "_pix"}, ImInput, 0);
      check({tag, "_first"}, px_first, 0);
      check({tag, "_last"}, px_last, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // kind 0: addr, 1: 0xFF-addr, 2: random
   task automatic load_set(input int kind, input bit toggle);
      int a = 0;
      for (int k = 0; k < D; k++)
         model[k] = (kind == 0) ? 8'(k) :
                    (kind == 1) ? 8'(255 - k) : 8'($urandom);
      check("ld_rdy_start", ld_ready, 1);
      while (a < D) begin
         ld_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_data  = ld_valid ? model[a] : 8'($urandom);
         if (ld_valid && a == D - 1) check("ld_rdy_last", ld_ready, 1);
         tick();
         if (ld_valid) a++;
      end
      check("ld_rdy_drop", ld_ready, 0);
      check("loaded_set", loaded, 1);
      ld_valid = 1'b1;
      repeat (3) begin
         ld_data = 8'($urandom);
         tick();
      end
      ld_valid = 1'b0;
      check("ready_hold", loaded, 1);
   endtask

   // mode 0 plain, 1 start at pixel 'at', 2 ld_clr+start at 'at', 3 rst at 'at'
   task automatic run_stream(input int mode, input int at);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_on", busy, 1);
      tick();
      check("lat_pxv", px_valid, 0);
      for (int k = 0; k < D; k++) begin
         start = (mode == 1 && k == at);
         tick();
         start = 1'b0;
         check($sformatf("pxv%0d", k), px_valid, 1);
         check($sformatf("pix%0d", k), ImInput, model[k]);
         check($sformatf("img%0d", k), img_idx, k / PIX);
         check($sformatf("first%0d", k), px_first, k == 0);
         check($sformatf("last%0d", k), px_last, k == D - 1);
         if (mode == 2 && k == at - 1) begin
            ld_clr = 1'b1;
            start  = 1'b1;
            tick();
            ld_clr = 1'b0;
            start  = 1'b0;
            chk_idle("clr");
            check("clr_rdy", ld_ready, 1);
            check("clr_loaded", loaded, 0);
            tick();
            check("clr_pxv2", px_valid, 0);
            return;
         end
         if (mode == 3 && k == at - 1) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_idle("rst");
            check("rst_rdy", ld_ready, 1);
            check("rst_loaded", loaded, 0);
            check("rst_img", img_idx, 0);
            repeat (5) begin
               tick();
               check("rst_nopx", px_valid, 0);
            end
            return;
         end
      end
      tick();
      chk_idle("end");
      check("end_loaded", loaded, 1);
      repeat (8) begin
         tick();
         check("no_extra", px_valid, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      ld_clr   = 1'b0;
      ld_valid = 1'b0;
      ld_data  = '0;
      start    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_idle("reset");
      check("reset_rdy", ld_ready, 1);
      check("reset_loaded", loaded, 0);
      check("reset_img", img_idx, 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      check("load_start_ign", busy, 0);
      check("load_start_rdy", ld_ready, 1);

      load_set(0, 1'b0);
      run_stream(0, 0);
      run_stream(1, $urandom_range(5, 250));
      run_stream(2, $urandom_range(10, 200));

      load_set(1, 1'b1);
      run_stream(0, 0);

      ld_clr = 1'b1;
      tick();
      ld_clr = 1'b0;
      check("clr_ready_rdy", ld_ready, 1);
      load_set(0, 1'b1);
      run_stream(0, 0);

      ld_clr = 1'b1;
      tick();
      ld_clr = 1'b0;
      load_set(2, 1'b1);
      run_stream(3, 100);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
